// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl
// Purpose  : Round-robin scheduler sharing one fixed-latency W x W -> 2W
//            unsigned sequential multiplier among NREQ requesters. Grants one
//            request at a time, starts the multiplier, waits out MUL_LAT and
//            returns the product with the requester index on a single
//            response channel with backpressure.
// Ports    : clk, n_rst            - clock, async active-low reset
//            req_valid/req_ready   - per-requester handshake (ready one-hot,
//                                    combinational, only in IDLE)
//            req_m/req_q           - packed operands, requester i at [i*W +: W]
//            rsp_valid/rsp_ready   - response handshake
//            rsp_id/rsp_data       - requester index and 2W-bit product
//            mul_start/mul_m/mul_q - multiplier start pulse and operands
//            mul_result            - multiplier product
//            busy                  - high whenever not IDLE
// Options  : `define MUL_ZERO_BYPASS_EN to answer zero-operand requests
//            directly (rsp_data=0) without starting the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int MUL_LAT = 34
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*W-1:0]       req_m,
  input  logic [NREQ*W-1:0]       req_q,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*W-1:0]          rsp_data,
  output logic                    mul_start,
  output logic [W-1:0]            mul_m,
  output logic [W-1:0]            mul_q,
  input  logic [2*W-1:0]          mul_result,
  output logic                    busy
);

  localparam int c_idw = $clog2(NREQ);
  localparam int c_cw  = $clog2(MUL_LAT + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // Loading MUL_LAT-1 makes the counter reach 0 in the cycle MUL_LAT after
  // the mul_start cycle, which is exactly when mul_result is final.
  localparam logic [c_cw-1:0]  c_cnt_load = c_cw'(MUL_LAT - 1);
  localparam logic [c_idw-1:0] c_id_last  = c_idw'(NREQ - 1);

  logic [1:0]       state_q,    state_d;
  logic [c_idw-1:0] ptr_q,      ptr_d;
  logic [c_cw-1:0]  cnt_q,      cnt_d;
  logic [W-1:0]     mul_m_q,    mul_m_d;
  logic [W-1:0]     mul_q_q,    mul_q_d;
  logic [c_idw-1:0] rsp_id_q,   rsp_id_d;
  logic [2*W-1:0]   rsp_data_q, rsp_data_d;

  logic             w_grant_found;
  logic [c_idw-1:0] w_grant_idx;
  logic [c_idw-1:0] w_scan_idx;
  logic [NREQ-1:0]  w_grant_oh;
  logic [W-1:0]     w_sel_m;
  logic [W-1:0]     w_sel_q;
  logic             w_zero_op;

  // Round-robin scan: ptr+1, ptr+2, ... wrapping at NREQ, first valid wins.
  // The index wraps explicitly so non-power-of-two NREQ works.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan_idx    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (w_scan_idx == c_id_last) begin
        w_scan_idx = '0;
      end else begin
        w_scan_idx = w_scan_idx + 1'b1;
      end
      if (!w_grant_found && req_valid[w_scan_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx;
      end
    end
  end

  // Operand mux and one-hot form of the winning index.
  always_comb begin
    w_sel_m    = '0;
    w_sel_q    = '0;
    w_grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == c_idw'(i)) begin
        w_sel_m       = req_m[i*W +: W];
        w_sel_q       = req_q[i*W +: W];
        w_grant_oh[i] = 1'b1;
      end
    end
  end

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero_op = (w_sel_m == '0) || (w_sel_q == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= c_st_idle;
      ptr_q      <= c_id_last;
      cnt_q      <= '0;
      mul_m_q    <= '0;
      mul_q_q    <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      mul_m_q    <= mul_m_d;
      mul_q_q    <= mul_q_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    mul_m_d    = mul_m_q;
    mul_q_d    = mul_q_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      c_st_idle: begin
        if (w_grant_found) begin
          mul_m_d  = w_sel_m;
          mul_q_d  = w_sel_q;
          rsp_id_d = w_grant_idx;
          ptr_d    = w_grant_idx;
          if (w_zero_op) begin
            rsp_data_d = '0;
            state_d    = c_st_resp;
          end else begin
            state_d = c_st_issue;
          end
        end
      end
      c_st_issue: begin
        cnt_d   = c_cnt_load;
        state_d = c_st_wait;
      end
      c_st_wait: begin
        if (cnt_q == '0) begin
          rsp_data_d = mul_result;
          state_d    = c_st_resp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      c_st_resp: begin
        if (rsp_ready) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready = (state_q == c_st_idle && w_grant_found) ? w_grant_oh : '0;
    mul_start = (state_q == c_st_issue);
    rsp_valid = (state_q == c_st_resp);
    busy      = (state_q != c_st_idle);
    mul_m     = mul_m_q;
    mul_q     = mul_q_q;
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_ctrl
// Purpose  : Scoreboard bench for mul_share_ctrl. A transaction-level model
//            tracks pending requests, the round-robin pointer and whether the
//            controller is idle; each predicted grant pushes the expected
//            response (id, product, arrival cycle) and the expected mul_start
//            cycle into queues that an independent monitor pops and compares.
//            A behavioural multiplier presents the product only in the cycle
//            MUL_LAT after mul_start and random data otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_share_ctrl;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int MUL_LAT = 34;
  localparam int IDW     = $clog2(NREQ);
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int             id;
    logic [2*W-1:0] data;
    int             due;
  } exp_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_m;
  logic [NREQ*W-1:0] req_q;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              mul_start;
  logic [W-1:0]      mul_m;
  logic [W-1:0]      mul_q;
  logic [2*W-1:0]    mul_result;
  logic              busy;

  mul_share_ctrl #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_m      (req_m),
    .req_q      (req_q),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .mul_start  (mul_start),
    .mul_m      (mul_m),
    .mul_q      (mul_q),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   nvec  = 0;
  int   nfail = 0;
  exp_t exp_q[$];
  int   start_q[$];

  // Model state.
  bit           pend_v [NREQ];
  logic [W-1:0] pend_m [NREQ];
  logic [W-1:0] pend_q [NREQ];
  bit           model_idle;
  int           mptr;
  bit           hs_pending;
  bit           rand_en;
  bit           bp_mode;

  function automatic logic [2*W-1:0] junk();
    logic [2*W-1:0] r;
    for (int i = 0; i < 2*W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Behavioural multiplier: product valid only in the cycle MUL_LAT after start.
  logic [2*W-1:0] mprod;
  int             mcnt;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mcnt       <= 0;
      mprod      <= '0;
      mul_result <= '0;
    end else if (mul_start) begin
      mprod      <= (2*W)'(mul_m) * (2*W)'(mul_q);
      mcnt       <= MUL_LAT - 1;
      mul_result <= junk();
    end else if (mcnt == 1) begin
      mul_result <= mprod;
      mcnt       <= 0;
    end else begin
      if (mcnt > 1) mcnt <= mcnt - 1;
      mul_result <= junk();
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
    pend_v[i] = 1'b1;
    pend_m[i] = m;
    pend_q[i] = q;
  endtask

  // One cycle of stimulus plus grant / busy prediction.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int   g;
    bit   zero;
    exp_t e;
    @(negedge clk);
    if (hs_pending) begin
      model_idle = 1'b1;
      hs_pending = 1'b0;
    end
    if (rand_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 3) == 0) post(i, rnd_op(), rnd_op());
        else if (pend_v[i] && $urandom_range(0, 15) == 0) pend_v[i] = 1'b0;
      end
    end
    rsp_ready = bp_mode ? 1'b0 : (rand_en ? ($urandom_range(0, 3) != 0) : 1'b1);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]     = pend_v[i];
      req_m[i*W +: W]  = pend_m[i];
      req_q[i*W +: W]  = pend_q[i];
    end
    #1;
    g = -1;
    if (model_idle) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (mptr + k) % NREQ;
        if (g < 0 && pend_v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    chk("busy", 128'(busy), 128'(!model_idle));
    if (g >= 0) begin
      zero   = BYPASS && (pend_m[g] == '0 || pend_q[g] == '0);
      e.id   = g;
      e.data = (2*W)'(pend_m[g]) * (2*W)'(pend_q[g]);
      e.due  = cyc + (zero ? 1 : MUL_LAT + 2);
      exp_q.push_back(e);
      if (!zero) start_q.push_back(cyc + 1);
      mptr       = g;
      pend_v[g]  = 1'b0;
      model_idle = 1'b0;
    end
    if (rsp_valid && rsp_ready) hs_pending = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      if (model_idle && !hs_pending && !any_pend() && exp_q.size() == 0 && start_q.size() == 0)
        return;
      step();
    end
    nvec++;
    nfail++;
    $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
  endtask

  task automatic reset_mid();
    @(negedge clk);
    n_rst     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_mul_start", 128'(mul_start), 128'(0));
    chk("rst_mul_m",     128'(mul_m),     128'(0));
    chk("rst_mul_q",     128'(mul_q),     128'(0));
    chk("rst_rsp_data",  128'(rsp_data),  128'(0));
    chk("rst_rsp_id",    128'(rsp_id),    128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    exp_q.delete();
    start_q.delete();
    model_idle = 1'b1;
    mptr       = NREQ - 1;
    hs_pending = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Monitor: mul_start pulses and responses against the queued expectations.
  bit   in_rsp = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    #2;
    if (!n_rst) begin
      in_rsp = 1'b0;
    end else begin
      if (start_q.size() > 0 && start_q[0] < cyc) begin
        nvec++;
        nfail++;
        $display("FAIL mul_start_missing: got no pulse in cycle %0d, required one", start_q[0]);
        void'(start_q.pop_front());
      end
      if (mul_start) begin
        nvec++;
        if (start_q.size() == 0 || start_q[0] != cyc) begin
          nfail++;
          $display("FAIL mul_start_unexpected: got pulse in cycle %0d, required none", cyc);
        end else begin
          void'(start_q.pop_front());
        end
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nfail++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d data=%0h, required rsp_valid=0",
                     rsp_id, rsp_data);
          end else begin
            cur    = exp_q.pop_front();
            in_rsp = 1'b1;
            chk("rsp_id",      128'(rsp_id),   128'(cur.id));
            chk("rsp_data",    128'(rsp_data), 128'(cur.data));
            chk("rsp_latency", 128'(cyc),      128'(cur.due));
          end
        end else begin
          chk("rsp_id_hold",   128'(rsp_id),   128'(cur.id));
          chk("rsp_data_hold", 128'(rsp_data), 128'(cur.data));
        end
        if (rsp_ready) in_rsp = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        nvec++;
        nfail++;
        $display("FAIL rsp_late: got no response by cycle %0d, required at cycle %0d",
                 cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    n_rst      = 1'b0;
    req_valid  = '0;
    req_m      = '0;
    req_q      = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_m[i] = '0;
      pend_q[i] = '0;
    end
    model_idle = 1'b1;
    mptr       = NREQ - 1;
    hs_pending = 1'b0;
    rand_en    = 1'b0;
    bp_mode    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy",      128'(busy),      128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_mul_start", 128'(mul_start), 128'(0));
    chk("reset_rsp_data",  128'(rsp_data),  128'(0));
    chk("reset_rsp_id",    128'(rsp_id),    128'(0));
    chk("reset_mul_m",     128'(mul_m),     128'(0));
    n_rst = 1'b1;

    // Single request, then max operands.
    post(1, 32'd3, 32'd5);
    drain();
    post(0, '1, '1);
    drain();

    // All four together from a fresh reset: served 0,1,2,3.
    reset_mid();
    for (int i = 0; i < NREQ; i++) post(i, W'(100 + i), W'(7 * i + 3));
    drain();

    // Fairness: after 2, requesters 0 and 3 together -> 3 first.
    post(2, 32'd21, 32'd2);
    drain();
    post(0, 32'd9, 32'd9);
    post(3, 32'd4, 32'd8);
    drain();

    // Backpressure: hold rsp_ready low 10 cycles in RESP with another request waiting.
    bp_mode = 1'b1;
    post(1, 32'd7, 32'd9);
    n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    chk("bp_reached_resp", 128'(rsp_valid), 128'(1));
    post(2, 32'd12, 32'd12);
    repeat (10) step();
    bp_mode = 1'b0;
    drain();

    // Reset during WAIT: nothing may come out afterwards; priority restarts at 0.
    post(1, 32'd11, 32'd13);
    repeat (15) step();
    reset_mid();
    repeat (40) step();
    post(3, 32'd5, 32'd6);
    post(0, 32'd2, 32'd3);
    drain();

    // Zero operands (bypassed or full latency depending on build).
    post(2, 32'd0, 32'd7);
    drain();
    post(1, 32'd5, 32'd0);
    drain();

    // Randomized traffic with random backpressure and withdrawals.
    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Round-robin scheduler that shares one sequential unsigned shift-add multiplier (W x W -> 2W, fixed latency) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, drives the multiplier's start/operand inputs, waits out its latency, and returns the 2W-bit product with the requester ID on one response channel with backpressure.
- Sits between the requesting engines and the multiplier instance; the only block allowed to drive the multiplier.

Parameters:
- NREQ, 4: number of requesters (2..8).
- W, 32: operand width; product width is 2W.
- MUL_LAT, 34: cycles from the mul_start-high cycle to the cycle in which mul_result holds the final product.

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_m  in  NREQ*W  multiplicands; requester i at [i*W +: W].
- req_q  in  NREQ*W  multipliers; same packing.
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NREQ)  requester index of the response.
- rsp_data  out  2W  product M*Q, unsigned.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_m  out  W  registered multiplicand, stable from ISSUE until back in IDLE.
- mul_q  out  W  registered multiplier, same stability.
- mul_result  in  2W  multiplier product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock clk; reset n_rst is asynchronous and active-low.
- Reset values: state=IDLE; mul_start, rsp_valid, busy = 0; mul_m, mul_q, rsp_data, rsp_id = 0; rr pointer = NREQ-1, so requester 0 has top priority first.
- Reset asserted mid-operation aborts immediately to these values. A pending response is discarded and no handshake completes.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, pick the first asserted index scanning ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Assert req_ready only for that index, in the same cycle.
  - At the edge: latch req_m/req_q into mul_m/mul_q, latch the index into rsp_id and ptr, go to ISSUE.
  - req_ready is all-zero in every other state.
- ISSUE: mul_start=1 for exactly this cycle; load the down-counter with MUL_LAT-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture mul_result into rsp_data at that edge and go to RESP.
  - Result: mul_result is sampled in the cycle MUL_LAT after the mul_start cycle.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new grant while in RESP; the earliest next grant is the IDLE cycle after the response handshake.
- Latency: request handshake at edge t; mul_start high in cycle t+1; rsp_valid rises at edge t+MUL_LAT+2.
- Requesters must hold req_m/req_q stable while req_valid is high and not granted; the controller does not check this.
- req_valid dropping before grant is allowed (no request lost or duplicated).
- A request arriving while busy waits; no queueing inside the block.
- Counter width: $clog2(MUL_LAT+1) bits; MUL_LAT >= 2 required.
- Single-requester case: the same requester may be granted back-to-back; the pointer wraps naturally.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted requester's req_m==0 or req_q==0, skip ISSUE/WAIT.
  - Go directly to RESP with rsp_data=0; mul_start is never pulsed.
  - rsp_valid rises at edge t+1.
  - Pointer update and rsp_id are unchanged from the normal flow.
- Undefined: zero operands take the normal multiplier path and full latency.

Test Plan:
- Single request: requester 1, M=3, Q=5, rsp_ready=1.
  - -> req_ready=4'b0010 for one cycle; mul_start one pulse with mul_m=3, mul_q=5.
  - -> rsp_valid at handshake+36 with rsp_data=15, rsp_id=1.
- Max operands: M=Q=32'hFFFF_FFFF on requester 0.
  - -> rsp_data=64'hFFFF_FFFE_0000_0001.
- All four req_valid high from reset, distinct operands.
  - -> grants and responses in order 0,1,2,3; exactly one mul_start per grant.
- Round-robin fairness: after requester 2 is served, assert req 0 and req 3 together.
  - -> 3 granted before 0.
- Backpressure and reset:
  - rsp_ready held low 10 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req_ready stays 0, busy=1; completes on rsp_ready.
  - Separate run: n_rst low during WAIT -> all outputs return to reset values immediately and no response appears.
- With MUL_ZERO_BYPASS_EN: requester 2, M=0, Q=7.
  - -> rsp_valid the cycle after grant, rsp_data=0, rsp_id=2, mul_start never high.
  - Without the macro: same stimulus gives full latency and rsp_data=0.
